// File: rtl/ttl_pkg.sv
// ---------------------------------------------------------------------------
// ttl_pkg
// Shared definitions for the 74xx-style clocked glue blocks.
//   - REQ_W / CODE_W : width of the request bus and of the encoded index.
//   - enc_state_t    : grant FSM state encoding (IDLE, PRESENT, GAP).
//   - prio_enc8      : 8-bit vector -> index of the highest set bit
//                      (bit 7 has the highest priority; all-zero maps to 0).
// ---------------------------------------------------------------------------
package ttl_pkg;

    localparam int REQ_W  = 8;
    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } enc_state_t;

    // Ascending scan so that the last (highest) set bit wins.
    function automatic logic [CODE_W-1:0] prio_enc8(input logic [REQ_W-1:0] vec);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < REQ_W; i++) begin
            if (vec[i]) begin
                idx = i[CODE_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/x74148_req_encoder_sync_bus.sv
// ---------------------------------------------------------------------------
// sync_bus
// W-bit multi-flop synchronizer. Every bit runs through its own chain of
// STAGES flops; the chains reset to all ones so that idle (high) active-low
// request lines do not look like requests while coming out of reset.
//   clk      in   1  core clock
//   reset_n  in   1  synchronous reset, active-low
//   d        in   W  asynchronous input bus
//   q        out  W  synchronized bus (last flop of each chain)
// ---------------------------------------------------------------------------
module sync_bus #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            logic [STAGES-1:0] chain_reg;

            // Shift towards the MSB; the new sample enters at bit 0.
            // Written as a shift-or so that STAGES=1 needs no special case.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    chain_reg <= '1;
                end else begin
                    chain_reg <= (chain_reg << 1) | STAGES'(d[gi]);
                end
            end

            assign q[gi] = chain_reg[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/x74148_req_encoder.sv
// ---------------------------------------------------------------------------
// x74148_req_encoder
// Clocked 8-to-3 priority encoder in the spirit of the 74148. Eight
// active-low request lines are synchronized, latched as pending bits and the
// highest pending index is offered to the consumer with a valid/ack
// handshake. Acknowledging a grant clears its pending bit (edge mode).
//
// Parameters
//   SYNC_STAGES  flops per request line in the synchronizer (1..4)
//   EDGE_MODE    1: pending latches on a synced falling edge of req_n
//                0: pending follows the synced low level of req_n
// Ports
//   clk      in   1  core clock
//   reset_n  in   1  synchronous reset, active-low
//   ei_n     in   1  enable input, active-low; gates new grants only
//   req_n    in   8  request lines, active-low, asynchronous; bit 7 highest
//   ack      in   1  consumer accepts code; honoured only while valid=1
//   code     out  3  granted index, true binary
//   valid    out  1  code is stable and awaiting ack
//   gs_n     out  1  group select, active-low (~valid)
//   eo_n     out  1  enable output, active-low: 0 when ei_n=0 and nothing pending
//   pending  out  8  latched request bits (status)
// ---------------------------------------------------------------------------
module x74148_req_encoder
    import ttl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ei_n,
    input  logic [REQ_W-1:0]  req_n,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              gs_n,
    output logic              eo_n,
    output logic [REQ_W-1:0]  pending
);

    // The edge detector stays disarmed until the synchronizer has been
    // refilled after reset and s_d has caught up with it. The chains reset
    // to ones, so without this a line held low across reset would produce
    // a spurious 1->0 transition as soon as the chain fills with real
    // samples and would be re-latched as a fresh request.
    localparam int WARM_CYCLES = SYNC_STAGES + 1;

    logic [REQ_W-1:0]  s;
    logic [REQ_W-1:0]  s_d_reg;
    logic [REQ_W-1:0]  set_vec;
    logic [REQ_W-1:0]  clr_vec;
    logic [REQ_W-1:0]  pend_reg;
    logic [REQ_W-1:0]  pend_next;
    logic [2:0]        warm_reg;
    logic              armed;

    enc_state_t        state_reg;
    logic [CODE_W-1:0] code_reg;
    logic              valid_reg;
    logic              gs_n_reg;
    logic              eo_n_reg;

    // -----------------------------------------------------------------------
    // Input synchronizer
    // -----------------------------------------------------------------------
    sync_bus #(
        .W      (REQ_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (req_n),
        .q       (s)
    );

    // -----------------------------------------------------------------------
    // Edge detect and post-reset warm-up
    // -----------------------------------------------------------------------
    assign armed = (warm_reg == 3'(WARM_CYCLES));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_d_reg  <= '1;
            warm_reg <= '0;
        end else begin
            s_d_reg <= s;
            if (!armed) begin
                warm_reg <= warm_reg + 3'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-line set/clear terms
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < REQ_W; gi++) begin : g_line
            assign set_vec[gi] = armed & s_d_reg[gi] & ~s[gi];
            assign clr_vec[gi] = ack & valid_reg & (code_reg == CODE_W'(gi));
        end

        if (EDGE_MODE != 0) begin : g_edge
            // A new edge in the same cycle as the ack of that line wins, so
            // the second request is not lost.
            assign pend_next = set_vec | (pend_reg & ~clr_vec);
        end else begin : g_level
            // Level mode: the source owns the line; ack only ends the grant.
            assign pend_next = ~s;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    // -----------------------------------------------------------------------
    // Grant FSM with registered outputs. gs_n and eo_n are loaded from the
    // same next values as valid and pending so all four move together.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            code_reg  <= '0;
            valid_reg <= 1'b0;
            gs_n_reg  <= 1'b1;
            eo_n_reg  <= 1'b1;
        end else begin
            eo_n_reg <= ei_n | (|pend_next);

            case (state_reg)
                IDLE: begin
                    if (!ei_n && (pend_reg != '0)) begin
                        code_reg  <= prio_enc8(pend_reg);
                        valid_reg <= 1'b1;
                        gs_n_reg  <= 1'b0;
                        state_reg <= PRESENT;
                    end
                end

                PRESENT: begin
                    // code is frozen here; newer or higher requests wait.
                    if (ack) begin
                        valid_reg <= 1'b0;
                        gs_n_reg  <= 1'b1;
                        state_reg <= GAP;
                    end
                end

                GAP: begin
                    // Dead cycle: the pending bit cleared by the ack becomes
                    // visible before IDLE picks the next winner.
                    state_reg <= IDLE;
                end

                default: begin
                    valid_reg <= 1'b0;
                    gs_n_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign code    = code_reg;
    assign valid   = valid_reg;
    assign gs_n    = gs_n_reg;
    assign eo_n    = eo_n_reg;
    assign pending = pend_reg;

endmodule
